// File: rtl/or_reduce_pipe.sv
// or_reduce_pipe: stallable registered OR-reduction tree over NUM_IN lanes with a sticky accumulator in the last stage
module or_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 8,
  parameter int FANIN  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_acc,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    out_any
);
  function automatic int stages();
    int n;
    int s;
    n = NUM_IN;
    s = 0;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction
  localparam int S = stages();
  logic [WIDTH-1:0] d   [S][NUM_IN];
  logic [WIDTH-1:0] sd  [S][NUM_IN];
  logic [WIDTH-1:0] nxt [S][NUM_IN];
  logic             v   [S];
  logic             a   [S];
  logic             l   [S];
  logic             sv  [S];
  logic             sa  [S];
  logic             sl  [S];
  logic             rdy [S];
  logic [WIDTH-1:0] acc;
  logic             absorb;
  // Entries past the live count of a stage stay zero, so partial groups OR only real lanes.
  always_comb begin
    logic free;
    free = out_ready;
    for (int i = S - 1; i >= 0; i--) begin
      free = free || !v[i];
      rdy[i] = free;
    end
    sv[0] = in_valid;
    sa[0] = in_acc;
    sl[0] = in_last;
    for (int j = 0; j < NUM_IN; j++) sd[0][j] = in_data[j*WIDTH +: WIDTH];
    for (int i = 1; i < S; i++) begin
      sv[i] = v[i-1];
      sa[i] = a[i-1];
      sl[i] = l[i-1];
      for (int j = 0; j < NUM_IN; j++) sd[i][j] = d[i-1][j];
    end
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        nxt[i][j] = '0;
        for (int k = 0; k < FANIN; k++)
          if (j * FANIN + k < NUM_IN) nxt[i][j] = nxt[i][j] | sd[i][j*FANIN+k];
      end
    end
    nxt[S-1][0] = nxt[S-1][0] | acc;
    absorb = sa[S-1] && !sl[S-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      for (int i = 0; i < S; i++) begin
        v[i] <= 1'b0;
        a[i] <= 1'b0;
        l[i] <= 1'b0;
        for (int j = 0; j < NUM_IN; j++) d[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < S; i++) begin
        if (rdy[i]) begin
          v[i] <= sv[i] && !(i == S - 1 && absorb);
          if (sv[i] && !(i == S - 1 && absorb)) begin
            for (int j = 0; j < NUM_IN; j++) d[i][j] <= nxt[i][j];
            a[i] <= sa[i];
            l[i] <= sl[i];
          end
        end
      end
      if (rdy[S-1] && sv[S-1]) acc <= absorb ? nxt[S-1][0] : '0;
    end
  end
  assign in_ready  = rst_n && rdy[0];
  assign out_valid = v[S-1];
  assign out_data  = d[S-1][0];
  assign out_last  = l[S-1];
  assign out_any   = |d[S-1][0];
endmodule

// File: doc/or_reduce_pipe.md
# or_reduce_pipe

Parametrised, pipelined, multi-lane OR-reduction engine with a valid/ready stream interface and an optional sticky accumulate mode. It generalises the two-input OR cell used throughout the AES decryption datapath into an N-lane, W-bit, fan-in-configurable registered tree. It aggregates status/flag vectors such as round error flags and zero-detect masks, and it can OR a multi-beat sequence into a single result. It sits between flag producers and the control FSM as a stallable pipeline stage.

## Interface
- WIDTH, 8, bits per lane
- NUM_IN, 8, number of input lanes (≥1)
- FANIN, 2, lanes combined per tree node per stage (≥2)
- Derived: S = max(1, ceil(log_FANIN(NUM_IN))) register stages
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_data  in  NUM_IN*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- in_acc  in  1  beat belongs to an accumulate sequence
- in_last  in  1  final beat of a sequence
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  OR of all lanes (and accumulated beats)
- out_last  out  1  copy of in_last of the emitting beat
- out_any  out  1  |out_data

## Operation
- Stage i (0..S-1) registers the OR of groups of FANIN entries from stage i-1 (stage 0 from in_data). Partial last groups are OR'd over the available entries only; missing entries are treated as 0.
- Each stage has its own valid bit. in_acc and in_last travel with the data.
- Stage advance: stage i loads when its register is empty or is being drained in the same cycle. Ready propagates combinationally: ready_i = !valid_i || ready_{i+1}, with ready_S = out_ready and in_ready = ready_0.
- Last stage contains a WIDTH-bit accumulator acc:
  - Beat with in_acc=1 and in_last=0 is absorbed: acc <= acc | tree_result. No output is produced.
  - Any other beat emits out_data = acc | tree_result, and acc is cleared in the same cycle.
- The last stage advances only when the output register is free or draining. This rule applies to absorbed beats as well.
- NUM_IN=1: S=1, and the single stage registers lane 0 (plus acc).
- Reset (rst_n=0 at a clock edge) clears all of the following:
  - all stage valids and all stage data
  - acc
  - out_valid=0, out_data=0, out_last=0, out_any=0
- in_ready is driven 0 while rst_n=0, including during the reset cycle itself.
- Reset mid-sequence discards all in-flight and partially accumulated data. No output results from it.

## Timing
- Latency: a beat accepted at edge t (in_valid && in_ready) appears with out_valid=1 after edge t+S-1, i.e. it is visible during cycle t+S when S=…
- Throughput: 1 beat/cycle with out_ready held 1.
- Stall: while out_valid && !out_ready, out_data, out_last and out_any are held stable. The pipeline fills up to S beats, then in_ready=0 in the same cycle.
- When out_ready rises, in_ready rises combinationally in the same cycle. There is no bubble.
- in_data, in_acc and in_last are sampled only on handshake. They are don't-care otherwise.
- Simultaneous drain and load at any stage: the old value leaves and the new value enters on the same edge.
- Emitting beat and acc clear occur on the same edge, so a back-to-back next sequence starts from acc=0.

## Test plan
All scenarios use WIDTH=8, NUM_IN=8, FANIN=2, so S=3.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1. Required: in_ready=0, out_valid=0, out_data=0x00, out_any=0. One cycle after release, in_ready=1.
- Single beat: lanes 0x01,0x02,…,0x80, in_acc=0, accepted at t. Required: out_valid=1 with out_data=0xFF and out_any=1 three cycles later, for exactly one transfer.
- Zero beat followed by beat 0x00…0x40: required outputs 0x00 (out_any=0) then 0x40 (out_any=1) on consecutive cycles.
- Accumulate: three beats with in_acc=1 and only lane 0 set, values 0x01, 0x10, 0x80 (in_last on the third). Required: exactly one output, 0x91 with out_last=1, then a following plain beat 0x02 outputs 0x02.
- Backpressure: stream 6 distinct beats with out_ready=0 for cycles 2–6. Required: in_ready drops after 3 beats are held, there is no loss or duplication, order is preserved, and out_data is stable during the stall.
- Reset mid-accumulate: absorb 0x01 and 0x20, pulse rst_n=0 for 1 cycle, then send plain beat 0x04. Required: the single output is 0x04.
